pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/bubble/halt sequencer for the 4-stage pipeline. Drives the stall, halt_sys
//  and NOP-insert controls of the fetch/decode, A (execute-in) and M (memory-in) stage registers.
//  Resolves load-use hazards, multicycle MUL/DIV occupancy, data-memory wait and HALT drain.
// PARAMETERS
//  MDU_CYCLES   4   EX occupancy of MUL/DIV in cycles (>=1); 1 = single-cycle, no stall
//  DRAIN_DEPTH  3   bubble cycles after HALT decode before freeze (>=1)
//  PERF_W       16  width of stall-cycle counter (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  ld_use_haz    in   1       decode: load-use hazard vs. instr in stage A
//  mdu_start     in   1       MUL/DIV entering EX this cycle
//  mem_busy      in   1       data memory not ready, level
//  halt_req      in   1       HALT opcode in decode
//  resume        in   1       restart request while halted
//  perf_clr      in   1       clear stall counter (PIPE_CTRL_PERF_EN only)
//  stall_fe      out  1       hold PC and IF/ID register
//  stall_a       out  1       hold stage A register
//  stall_m       out  1       hold stage M register
//  bubble_a      out  1       load NOP into stage A (reg_wr=0, memc=0, R0_en=0)
//  bubble_m      out  1       load NOP into stage M
//  halt_sys      out  1       freeze every stage register
//  stall_cycles  out  PERF_W  saturating stall count (0 when macro absent)
// BEHAVIOUR
//  - State: RUN, MDU, DRAIN, HALTED; down-counter cnt. Outputs combinational from state/inputs.
//  - Reset (rst_n=0): state=RUN, cnt=0, stall_cycles=0; all outputs forced 0 while asserted.
//  - mem_busy=1 (any state except HALTED): stall_fe=stall_a=stall_m=1, cnt frozen, no transition.
//  - Priority in RUN when !mem_busy: mdu_start > ld_use_haz > halt_req.
//  - RUN+ld_use_haz: stall_fe=1, bubble_a=1, stall_a=0 same cycle; remain RUN (1-cycle penalty).
//  - RUN+mdu_start, MDU_CYCLES>1: start cycle unstalled; next state MDU, cnt=MDU_CYCLES-1.
//    MDU: stall_fe=stall_a=1, bubble_m=1; cnt-- per non-busy cycle; cnt==1 & !mem_busy -> RUN.
//    Exactly MDU_CYCLES-1 stall cycles absent mem_busy. ld_use_haz/halt_req ignored in MDU.
//  - RUN+halt_req: -> DRAIN, cnt=DRAIN_DEPTH. DRAIN: stall_fe=1, bubble_a=1; cnt-- per non-busy
//    cycle; cnt==1 & !mem_busy -> HALTED.
//  - HALTED: halt_sys=1, stall_fe=1, all else 0; mem_busy ignored. resume=1 -> RUN next cycle.
//  - resume outside HALTED ignored. Same-cycle ld_use_haz+halt_req: bubble now, DRAIN next cycle.
//  - Reset mid-MDU/DRAIN/HALTED: immediate return to RUN, cnt=0.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: stall_cycles += 1 each cycle stall_fe=1 & !halt_sys, saturates at
//  all-ones; perf_clr=1 zeroes it next edge (clear wins over increment).
//  Undefined: counter not built, stall_cycles tied 0, perf_clr unused; ports remain.
// STRUCTURE
//  alu_pkg: typedef enum logic [1:0] pipe_ctrl_state_e {PC_RUN, PC_MDU, PC_DRAIN, PC_HALTED}.
//  Sub-module pipe_ctrl_timer: loadable down-counter (load, value, dec, hold, is_one) shared
//  by MDU and DRAIN. FSM and output decode stay in this module.
// TESTING
//  1 reset; ld_use_haz 1 cycle -> stall_fe=1, bubble_a=1, stall_a=0 that cycle; all 0 next cycle.
//  2 MDU_CYCLES=4, mdu_start 1 cycle -> stall_fe/stall_a/bubble_m high exactly 3 cycles, then RUN.
//  3 mem_busy 2 cycles in MDU 2nd cycle -> stall_m=1 those cycles; MDU stalling lasts 5 cycles.
//  4 DRAIN_DEPTH=3, halt_req -> bubble_a 3 cycles, then halt_sys=1 held; resume -> 0 next cycle.
//  5 ld_use_haz+halt_req same cycle -> bubble_a that cycle, DRAIN entered next cycle.
//  6 rst_n low in DRAIN cnt=2 -> outputs 0 at once, RUN after release; PERF_EN: 10 stalls -> 10.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipeline stall/bubble/halt sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_MDU    = 2'd1,
    PC_DRAIN  = 2'd2,
    PC_HALTED = 2'd3
  } pipe_ctrl_state_e;

endpackage : alu_pkg

// File: rtl/pipe_ctrl_timer.sv
// Loadable down-counter shared by the MUL/DIV occupancy and HALT drain phases.
module pipe_ctrl_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  input  logic         hold,
  output logic         is_one
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down while not held, stopping at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && !hold && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign is_one = (cnt == W'(1));

endmodule : pipe_ctrl_timer

// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble/halt sequencer for the 4-stage pipeline.
// Optional stall-cycle performance counter: define PIPE_CTRL_PERF_EN.
module pipe_stall_ctrl
  import alu_pkg::*;
#(
  parameter int MDU_CYCLES  = 4,
  parameter int DRAIN_DEPTH = 3,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_use_haz,
  input  logic              mdu_start,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              perf_clr,
  output logic              stall_fe,
  output logic              stall_a,
  output logic              stall_m,
  output logic              bubble_a,
  output logic              bubble_m,
  output logic              halt_sys,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int CNT_MAX = (MDU_CYCLES > DRAIN_DEPTH) ? MDU_CYCLES : DRAIN_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  pipe_ctrl_state_e state_q, state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_dec;
  logic             tmr_is_one;

  pipe_ctrl_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .dec    (tmr_dec),
    .hold   (mem_busy),
    .is_one (tmr_is_one)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PC_RUN;
    else        state_q <= state_d;
  end

  // Next-state and output decode; all outputs held low while reset is asserted.
  // A load-use bubble with a simultaneous HALT still queues the drain for the next cycle.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_dec   = 1'b0;
    stall_fe  = 1'b0;
    stall_a   = 1'b0;
    stall_m   = 1'b0;
    bubble_a  = 1'b0;
    bubble_m  = 1'b0;
    halt_sys  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        PC_RUN: begin
          if (mem_busy) begin
            stall_fe = 1'b1;
            stall_a  = 1'b1;
            stall_m  = 1'b1;
          end else if (mdu_start) begin
            if (MDU_CYCLES > 1) begin
              state_d   = PC_MDU;
              tmr_load  = 1'b1;
              tmr_value = CNT_W'(MDU_CYCLES - 1);
            end
          end else begin
            if (ld_use_haz) begin
              stall_fe = 1'b1;
              bubble_a = 1'b1;
            end
            if (halt_req) begin
              state_d   = PC_DRAIN;
              tmr_load  = 1'b1;
              tmr_value = CNT_W'(DRAIN_DEPTH);
            end
          end
        end
        PC_MDU: begin
          stall_fe = 1'b1;
          stall_a  = 1'b1;
          if (mem_busy) begin
            stall_m = 1'b1;
          end else begin
            bubble_m = 1'b1;
            tmr_dec  = 1'b1;
            if (tmr_is_one) state_d = PC_RUN;
          end
        end
        PC_DRAIN: begin
          stall_fe = 1'b1;
          if (mem_busy) begin
            stall_a = 1'b1;
            stall_m = 1'b1;
          end else begin
            bubble_a = 1'b1;
            tmr_dec  = 1'b1;
            if (tmr_is_one) state_d = PC_HALTED;
          end
        end
        PC_HALTED: begin
          halt_sys = 1'b1;
          stall_fe = 1'b1;
          if (resume) state_d = PC_RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q;

  // Saturating count of front-end stall cycles outside HALT; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (perf_clr) begin
      perf_q <= '0;
    end else if (stall_fe && !halt_sys && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign stall_cycles = perf_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
`endif

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int MDU_CYCLES  = 4;
  localparam int DRAIN_DEPTH = 3;
  localparam int PERF_W      = 16;

  logic              clk;
  logic              rst_n;
  logic              ld_use_haz, mdu_start, mem_busy, halt_req, resume, perf_clr;
  logic              stall_fe, stall_a, stall_m, bubble_a, bubble_m, halt_sys;
  logic [PERF_W-1:0] stall_cycles;

  pipe_stall_ctrl #(
    .MDU_CYCLES  (MDU_CYCLES),
    .DRAIN_DEPTH (DRAIN_DEPTH),
    .PERF_W      (PERF_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_use_haz   (ld_use_haz),
    .mdu_start    (mdu_start),
    .mem_busy     (mem_busy),
    .halt_req     (halt_req),
    .resume       (resume),
    .perf_clr     (perf_clr),
    .stall_fe     (stall_fe),
    .stall_a      (stall_a),
    .stall_m      (stall_m),
    .bubble_a     (bubble_a),
    .bubble_m     (bubble_m),
    .halt_sys     (halt_sys),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model: remaining stall/drain cycles as plain integers.
  int                m_mdu_left;
  int                m_drain_left;
  bit                m_halted;
  logic [PERF_W-1:0] m_perf;
  logic [5:0]        m_out;   // {fe, a, m, bub_a, bub_m, halt}

  function automatic logic [5:0] model_out(bit ld, bit md, bit mb);
    if (m_halted)              return 6'b100001;
    if (mb)                    return 6'b111000;
    if (m_mdu_left > 0)        return 6'b110010;
    if (m_drain_left > 0)      return 6'b100100;
    if (md)                    return 6'b000000;
    if (ld)                    return 6'b100100;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_mdu_left   = 0;
    m_drain_left = 0;
    m_halted     = 1'b0;
    m_perf       = '0;
  endtask

  task automatic model_edge(bit md, bit mb, bit hr, bit rs, bit pc, logic [5:0] o);
    if (pc) m_perf = '0;
    else if (o[5] && !o[0] && m_perf != '1) m_perf = m_perf + 1'b1;
    if (m_halted) begin
      if (rs) m_halted = 1'b0;
    end else if (mb) begin
    end else if (m_mdu_left > 0) begin
      m_mdu_left--;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1'b1;
    end else if (md) begin
      m_mdu_left = MDU_CYCLES - 1;
    end else if (hr) begin
      m_drain_left = DRAIN_DEPTH;
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [PERF_W-1:0] exp_perf();
`ifdef PIPE_CTRL_PERF_EN
    return m_perf;
`else
    return '0;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model on the edge.
  task automatic step(string tag, bit ld, bit md, bit mb, bit hr, bit rs, bit pc);
    ld_use_haz = ld; mdu_start = md; mem_busy = mb;
    halt_req = hr; resume = rs; perf_clr = pc;
    #2;
    m_out = model_out(ld, md, mb);
    check({tag, ".ctl"}, 32'({stall_fe, stall_a, stall_m, bubble_a, bubble_m, halt_sys}), 32'(m_out));
    check({tag, ".perf"}, 32'(stall_cycles), 32'(exp_perf()));
    @(posedge clk);
    model_edge(md, mb, hr, rs, pc, m_out);
    #1;
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_use_haz = 1'b1; mdu_start = 1'b0; mem_busy = 1'b1;
    halt_req = 1'b0; resume = 1'b0; perf_clr = 1'b0;
    model_reset();
    #12;
    check("reset.ctl", 32'({stall_fe, stall_a, stall_m, bubble_a, bubble_m, halt_sys}), 32'd0);
    check("reset.perf", 32'(stall_cycles), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use hazard: bubble into A for one cycle only.
    step("lduse", 1, 0, 0, 0, 0, 0);
    idle("lduse_after", 1);

    // MUL/DIV occupancy: start cycle unstalled, then MDU_CYCLES-1 stall cycles.
    step("mdu_start", 0, 1, 0, 0, 0, 0);
    idle("mdu", 4);

    // Memory wait inside MDU extends the stall window.
    step("mdu2_start", 0, 1, 0, 0, 0, 0);
    idle("mdu2_c1", 1);
    step("mdu2_busy", 0, 0, 1, 0, 0, 0);
    step("mdu2_busy", 0, 0, 1, 0, 0, 0);
    idle("mdu2_tail", 3);

    // HALT drain, freeze, resume.
    step("halt_req", 0, 0, 0, 1, 0, 0);
    idle("drain", 3);
    step("halted_busy", 0, 0, 1, 0, 0, 0);
    idle("halted", 1);
    step("resume", 0, 0, 0, 0, 1, 0);
    idle("resumed", 1);

    // Load-use and HALT together: bubble now, drain next cycle.
    step("lduse_halt", 1, 0, 0, 1, 0, 0);
    idle("lh_drain", 4);
    step("lh_resume", 0, 0, 0, 0, 1, 0);

    // Reset mid-drain with two cycles left.
    step("rst_halt", 0, 0, 0, 1, 0, 0);
    idle("rst_drain", 1);
    ld_use_haz = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.ctl", 32'({stall_fe, stall_a, stall_m, bubble_a, bubble_m, halt_sys}), 32'd0);
    check("rst_mid.perf", 32'(stall_cycles), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle("rst_run", 2);

    // Ten load-use stalls after a clear.
    step("perf_clr", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("perf_ld", 1, 0, 0, 0, 0, 0);
    #2;
`ifdef PIPE_CTRL_PERF_EN
    check("perf10", 32'(stall_cycles), 32'd10);
`else
    check("perf10", 32'(stall_cycles), 32'd0);
`endif
    @(posedge clk); #1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
